// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for nibble_serial_adder: FSM state type, the nibble
// width and a helper that turns an operand width into a nibble count.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ripple.sv
// RippleAdderFourBits: 4-bit ripple-carry slice used once per cycle by
// nibble_serial_adder. bp is the block-propagate term (all four bit
// positions propagate), used only when the prop_all feature is built in.
module RippleAdderFourBits
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                bp
);

    logic [NIBBLE_W:0] c;

    // Bit-serial ripple through the four full adders of the slice.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]     = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co = c[NIBBLE_W];
    assign bp = &(x ^ y);

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that pushes one nibble per clock
// through a single 4-bit ripple slice, chaining the carry between cycles.
// Optional feature macro: PROP_ALL_EN adds the prop_all output (a^b all ones).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Input side: in_ready is high only in IDLE (and not in reset);
// a, b and cin are captured on the accepting edge. Output side: out_valid is
// high only in DONE, sum/cout are stable for as long as out_valid is high,
// and the result is dropped on the edge where out_ready is seen. in_ready
// and out_valid decode the state register only; out_ready never reaches
// in_ready combinationally.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
`ifdef PROP_ALL_EN
    output logic             prop_all,
`endif
    output logic [1:0]       state_dbg
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    nsa_state_t           state;
    nsa_state_t           state_d;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic                 carry;
    logic [IDX_W-1:0]     idx;
    logic [WIDTH-1:0]     sum_q;
    logic                 cout_q;
    logic [WIDTH-1:0]     res_full;
    logic [NIBBLE_W-1:0]  slice_sum;
    logic                 slice_co;
    logic                 last;

    assign last = (idx == IDX_W'(NIB - 1));

    // Per-cycle slice: low nibble of each shifted operand plus the chained carry.
`ifdef PROP_ALL_EN
    logic slice_bp;
    RippleAdderFourBits u_slice (
        .x  (opa[NIBBLE_W-1:0]),
        .y  (opb[NIBBLE_W-1:0]),
        .ci (carry),
        .s  (slice_sum),
        .co (slice_co),
        .bp (slice_bp)
    );
`else
    RippleAdderFourBits u_slice (
        .x  (opa[NIBBLE_W-1:0]),
        .y  (opb[NIBBLE_W-1:0]),
        .ci (carry),
        .s  (slice_sum),
        .co (slice_co),
        .bp ()
    );
`endif

    // Partial-result shift register. Only the upper WIDTH-4 bits are kept:
    // the nibble entering this cycle comes straight from the slice, so the
    // full sum is {slice_sum, res} on the last RUN cycle.
    if (NIB > 1) begin : g_res
        logic [WIDTH-NIBBLE_W-1:0] res;

        assign res_full = {slice_sum, res};

        // Shift each new slice nibble in from the top while running.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                res <= '0;
            end else if (state == RUN) begin
                res <= res_full[WIDTH-1:NIBBLE_W];
            end
        end
    end else begin : g_res_single
        assign res_full = slice_sum;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operand capture, nibble sequencing, carry chaining and result latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    carry <= slice_co;
                    opa   <= opa >> NIBBLE_W;
                    opb   <= opb >> NIBBLE_W;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        sum_q  <= res_full;
                        cout_q <= slice_co;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PROP_ALL_EN
    logic prop_acc;
    logic prop_q;

    // AND-accumulate the per-nibble block propagate; publish it with the sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prop_acc <= 1'b0;
            prop_q   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                prop_acc <= 1'b1;
            end else if (state == RUN) begin
                prop_acc <= prop_acc & slice_bp;
                if (last) begin
                    prop_q <= prop_acc & slice_bp;
                end
            end
        end
    end

    assign prop_all = prop_q;
`endif

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder: a WIDTH=16 instance checked every cycle
// against a behavioural model (arithmetic sum, acceptance-time latency),
// plus a WIDTH=4 instance with directed and random checks.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic         rst_n;
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [W-1:0] a, b, sum;
    logic [1:0]   state_dbg;
`ifdef PROP_ALL_EN
    logic         prop_all;
`endif

    logic         iv4, ir4, cin4, ov4, or4, c4, busy4;
    logic [3:0]   a4, b4, s4;
    logic [1:0]   st4;
`ifdef PROP_ALL_EN
    logic         p4;
`endif

    nibble_serial_adder #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
`ifdef PROP_ALL_EN
        .prop_all  (prop_all),
`endif
        .state_dbg (state_dbg)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (ov4),
        .out_ready (or4),
        .sum       (s4),
        .cout      (c4),
        .busy      (busy4),
`ifdef PROP_ALL_EN
        .prop_all  (p4),
`endif
        .state_dbg (st4)
    );

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result: {prop, cout, sum} from plain arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] t;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return {&(x ^ y), t};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_res  = '0;
    bit           in_flight = 1'b0;
    int           acc_cyc   = 0;

    always @(negedge clk) begin
        bit exp_ov;
        bit exp_ir;
        if (cyc >= 1) begin
            exp_ov = in_flight && (cyc >= acc_cyc + NIB);
            exp_ir = !in_flight && (rst_n === 1'b1);
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, exp_ir);
            chk("busy", busy, in_flight);
            if (exp_ov) begin
                if (exp_q.size() == 0) chk("exp_q_empty", 1, 0);
                else last_res = exp_q[0];
            end
            chk("sum", sum, last_res[W-1:0]);
            chk("cout", cout, last_res[W]);
`ifdef PROP_ALL_EN
            chk("prop_all", prop_all, last_res[W+1]);
`endif
            if (rst_n !== 1'b1) begin
                in_flight = 1'b0;
                exp_q.delete();
                last_res  = '0;
            end else if (exp_ir && in_valid) begin
                in_flight = 1'b1;
                acc_cyc   = cyc + 1;
                exp_q.push_back(model(a, b, cin));
            end else if (exp_ov && out_ready) begin
                in_flight = 1'b0;
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- out_ready driver ----------------
    bit   rand_ready = 1'b0;
    logic ready_val  = 1'b1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // ---------------- driver tasks ----------------
    int acc_t = 0;

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(posedge clk);
        #1;
        a        = x;
        b        = y;
        cin      = c;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc_t    = cyc;
                in_valid = 1'b0;
                a        = W'($urandom);
                b        = W'($urandom);
                cin      = 1'($urandom_range(0, 1));
                return;
            end
        end
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output logic [W-1:0] s, output logic c);
        lat = -1;
        s   = '0;
        c   = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - acc_t;
                s   = sum;
                c   = cout;
                return;
            end
        end
        chk("wait_out_timeout", 0, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int           lat;
        logic [W-1:0] rs;
        logic         rc;
        int           t4;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; or4 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        // Basic add with exact latency and turnaround.
        send(16'h1234, 16'h4321, 1'b0);
        wait_out(lat, rs, rc);
        chk("add1_latency", lat, NIB);
        chk("add1_sum", rs, 16'h5555);
        chk("add1_cout", rc, 0);
        @(negedge clk);
        chk("add1_in_ready_after", in_ready, 1);

        send(16'hFFFF, 16'h0001, 1'b0);
        wait_out(lat, rs, rc);
        chk("wrap_sum", rs, 16'h0000);
        chk("wrap_cout", rc, 1);

        send(16'hFFFF, 16'hFFFF, 1'b1);
        wait_out(lat, rs, rc);
        chk("max_sum", rs, 16'hFFFF);
        chk("max_cout", rc, 1);

        send(16'hF0F0, 16'h0F0F, 1'b0);
        wait_out(lat, rs, rc);
        chk("prop_sum", rs, 16'hFFFF);
`ifdef PROP_ALL_EN
        chk("prop_one", prop_all, 1);
`endif
        send(16'hF0F0, 16'h0F0E, 1'b0);
        wait_out(lat, rs, rc);
        chk("prop0_sum", rs, 16'hFFFE);
`ifdef PROP_ALL_EN
        chk("prop_zero", prop_all, 0);
`endif

        // Backpressure: result held, second offer not consumed.
        ready_val = 1'b0;
        send(16'h0F0F, 16'h1111, 1'b1);
        wait_out(lat, rs, rc);
        chk("bp_sum", rs, 16'h2021);
        @(posedge clk);
        #1;
        a = 16'h00AA; b = 16'h0055; cin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_sum", sum, 16'h2021);
            chk("bp_hold_cout", cout, 0);
        end
        ready_val = 1'b1;
        send(16'h00AA, 16'h0055, 1'b0);
        wait_out(lat, rs, rc);
        chk("bp_second_sum", rs, 16'h00FF);

        // Reset in the second RUN cycle aborts the operation.
        send(16'h1357, 16'h2468, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_in_ready", in_ready, 1);
        send(16'h00FF, 16'h0001, 1'b0);
        wait_out(lat, rs, rc);
        chk("post_abort_sum", rs, 16'h0100);
        chk("post_abort_cout", rc, 0);

        // Random traffic with random backpressure; the compare process checks.
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(pick(), pick(), 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
        chk("drain_idle", in_ready, 1);

        // WIDTH=4 instance: single-cycle RUN.
        for (int n = 0; n < 31; n++) begin
            logic [4:0] e;
            int         waited;
            @(posedge clk);
            #1;
            if (n == 0) begin
                a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1;
            end else begin
                a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom_range(0, 1));
            end
            e   = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
            iv4 = 1'b1;
            waited = 0;
            while (!ir4 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (waited == 0) @(negedge clk);
            chk("w4_in_ready", ir4, 1);
            @(posedge clk);
            #1;
            t4  = cyc;
            iv4 = 1'b0;
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!ov4 && waited < 20);
            chk("w4_latency", cyc - t4, 1);
            chk("w4_sum", s4, e[3:0]);
            chk("w4_cout", c4, e[4]);
            if (n == 0) begin
                chk("w4_lit_sum", s4, 4'h2);
                chk("w4_lit_cout", c4, 1);
            end
`ifdef PROP_ALL_EN
            chk("w4_prop", p4, &(a4 ^ b4));
`endif
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
